button_panel_interface: RTL and testbench
=========================================

Name: button_panel_interface

Overview:
- Physical-side front end for the two-car, 7-floor elevator controller.
- Synchronises and debounces raw hall and car push-buttons, then latches floor requests into pending registers.
- Drives those requests into the controller as realFloorButton / realInternalButton1/2.
- Clears each request, and its lamp, when the controller's next* request outputs drop that bit (request served).

Parameters:
- CLK_PER_DEBOUNCE, 2000000: clk cycles between debounce samples.
- DEBOUNCE_SAMPLES, 3: consecutive equal samples needed to change debounced level (range 2..8).
- STUCK_SAMPLES, 255: sample count for stuck detection (optional feature only).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rawHall  in  12  raw hall buttons; bit k = controller floor-button index k+1 (odd internal index = up of floor, even = down)
- rawCar1  in  [9:1]  car 1 raw buttons; 1..7 = floors, 8 = door-open, 9 = door-close
- rawCar2  in  [9:1]  car 2 raw buttons, same map
- nextRealFloorButton  in  12  controller's remaining hall requests
- nextRealInternalButton1  in  [9:1]  controller's remaining car-1 requests
- nextRealInternalButton2  in  [9:1]  controller's remaining car-2 requests
- realFloorButton  out  12  pending hall requests to controller
- realInternalButton1  out  [9:1]  car-1 requests to controller
- realInternalButton2  out  [9:1]  car-2 requests to controller
- hallLamp  out  12  hall call lamps
- carLamp1  out  [9:1]  car-1 button lamps
- carLamp2  out  [9:1]  car-2 button lamps

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-high.
- On reset, clear all of the following to 0 immediately:
  - synchronisers, sample shift registers, debounced levels and tick counter
  - pending registers and ack-edge history
  - every output
- Reset mid-debounce or with requests pending discards them all; no press event fires on reset release.
- Synchroniser: every raw bit passes through a 2-flop synchroniser.
- Tick counter:
  - counts 0..CLK_PER_DEBOUNCE-1 and wraps to 0.
  - tick is a 1-cycle strobe when the counter equals CLK_PER_DEBOUNCE-1.
  - counter width is $clog2(CLK_PER_DEBOUNCE).
- Per-button debounce (30 instances):
  - On tick, shift the synchronised bit into a DEBOUNCE_SAMPLES-wide shift register.
  - Debounced level becomes 1 when the register is all ones, 0 when all zeros, and otherwise holds.
- Press event: 1-cycle pulse on the debounced 0->1 transition.
- Ack event: 1-cycle pulse when the matching next* bit goes 1->0; its previous value is registered.
- Latched buttons (hall bits and car bits 1..7):
  - pending <= (pending & ~ack) | press
  - Press and ack in the same cycle: press wins, bit stays 1.
  - Press on an already pending bit: no change.
- Momentary buttons (car bits 8, 9):
  - not latched; output equals the debounced level.
  - ack on these bits is ignored.
- Outputs:
  - realFloorButton = pending hall bits; realInternalButtonN = pending/momentary car bits.
  - Every lamp equals its corresponding request output bit.
- Latency: a raw input stable from cycle t is guaranteed to reach the output within 2 + DEBOUNCE_SAMPLES*CLK_PER_DEBOUNCE + 2 cycles.
- Ack latency: the output bit clears 2 cycles after next* falls (edge register, then pending register).
- Releasing a button never clears its request.

Optional Feature:
- Macro: STUCK_BUTTON_MASK_EN.
- When defined:
  - Each button has a saturating 8-bit counter that counts ticks while the debounced level is 1 and resets to 0 when the level is 0.
  - When the counter reaches STUCK_SAMPLES, the button is masked: its press events are suppressed until its debounced level returns to 0.
  - An extra output port stuckFault (1 bit) is the OR of all mask bits; it resets to 0.
- When not defined: no counters, no masking, no stuckFault port.

Decomposition:
- Shared header Elevator.vh holds:
  - FLOOR_COUNT = 7, HALL_BITS = 12, CAR_BITS = 9
  - DOOR_OPEN_BIT = 8, DOOR_CLOSE_BIT = 9
  - ON/OFF constants
- Sub-module button_debouncer, one instance per button, contains:
  - synchroniser and sample shift register
  - debounced level and press pulse
  - optional stuck logic
- It takes the shared tick as an input; the tick counter lives in the top.

Test Plan (CLK_PER_DEBOUNCE=4, DEBOUNCE_SAMPLES=3):
1. rawHall[2]=1 held for 20 cycles -> realFloorButton[2] and hallLamp[2] rise within 16 cycles and stay 1 after release.
2. rawCar1[3] toggled every 3 cycles for 40 cycles, then held at 0 -> realInternalButton1[3] stays 0 throughout.
3. Pending realFloorButton[5]=1; drive nextRealFloorButton[5] 1 then 0 -> output clears exactly 2 cycles after the fall.
4. rawCar2[8] held for 30 cycles -> realInternalButton2[8] follows the debounced level and falls after release; a next* 1->0 on bit 8 is ignored.
5. Press event on hall bit 0 in the same cycle as its ack -> bit remains 1.
6. Assert reset asynchronously mid-debounce with 3 bits pending -> all outputs are 0 before the next clk edge, and no pending bit sets after reset release while raw inputs are 0.

Source files
------------

// File: rtl/button_panel_interface_pkg.sv
// Shared elevator panel constants and the button-index map used by button_panel_interface.
package button_panel_interface_pkg;

  localparam int FLOOR_COUNT    = 7;
  localparam int HALL_BITS      = 12;
  localparam int CAR_BITS       = 9;
  localparam int DOOR_OPEN_BIT  = 8;
  localparam int DOOR_CLOSE_BIT = 9;
  localparam logic ON  = 1'b1;
  localparam logic OFF = 1'b0;

  // Flat index: hall 0..11, car1 bits 1..9 at 12..20, car2 bits 1..9 at 21..29.
  localparam int BUTTON_COUNT = HALL_BITS + 2 * CAR_BITS;

  typedef enum logic {
    BTN_LATCHED,
    BTN_MOMENTARY
  } btnKind_t;

  function automatic btnKind_t buttonKind(input int unsigned idx);
    int unsigned carBit;
    if (idx < HALL_BITS) return BTN_LATCHED;
    carBit = ((idx - HALL_BITS) % CAR_BITS) + 1;
    if (carBit > FLOOR_COUNT && (carBit == DOOR_OPEN_BIT || carBit == DOOR_CLOSE_BIT))
      return BTN_MOMENTARY;
    return BTN_LATCHED;
  endfunction

  function automatic logic [BUTTON_COUNT-1:0] momentaryMask();
    logic [BUTTON_COUNT-1:0] mask;
    mask = '0;
    for (int unsigned i = 0; i < BUTTON_COUNT; i++)
      mask[i] = (buttonKind(i) == BTN_MOMENTARY);
    return mask;
  endfunction

endpackage

// File: rtl/button_panel_interface_debouncer.sv
// Single-button synchroniser, tick-sampled debouncer and press-edge detector.
// Optional STUCK_BUTTON_MASK_EN adds a saturating hold counter that masks press events.
module button_debouncer
  import button_panel_interface_pkg::*;
#(
  parameter int DEBOUNCE_SAMPLES = 3
`ifdef STUCK_BUTTON_MASK_EN
  , parameter int STUCK_SAMPLES = 255
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic tick,
  output logic level,
  output logic press
`ifdef STUCK_BUTTON_MASK_EN
  , output logic stuck
`endif
);

  logic                        syncA;
  logic                        syncB;
  logic [DEBOUNCE_SAMPLES-1:0] samples;
  logic                        levelD;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      syncA   <= OFF;
      syncB   <= OFF;
      samples <= '0;
      level   <= OFF;
      levelD  <= OFF;
    end else begin
      syncA  <= raw;
      syncB  <= syncA;
      if (tick) samples <= {samples[DEBOUNCE_SAMPLES-2:0], syncB};
      if (&samples)       level <= ON;
      else if (~|samples) level <= OFF;
      levelD <= level;
    end
  end

`ifdef STUCK_BUTTON_MASK_EN
  logic [7:0] holdCnt;
  logic       mask;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      holdCnt <= '0;
      mask    <= OFF;
    end else if (level == OFF) begin
      holdCnt <= '0;
      mask    <= OFF;
    end else begin
      if (tick && holdCnt != '1) holdCnt <= holdCnt + 8'd1;
      if (holdCnt >= 8'(STUCK_SAMPLES)) mask <= ON;
    end
  end

  assign press = level & ~levelD & ~mask;
  assign stuck = mask;
`else
  assign press = level & ~levelD;
`endif

endmodule

// File: rtl/button_panel_interface.sv
// Button panel front end: debounces hall/car buttons and latches requests until served.
// Optional STUCK_BUTTON_MASK_EN adds per-button stuck masking and the stuckFault output.
module button_panel_interface
  import button_panel_interface_pkg::*;
#(
  parameter int CLK_PER_DEBOUNCE = 2000000,
  parameter int DEBOUNCE_SAMPLES = 3
`ifdef STUCK_BUTTON_MASK_EN
  , parameter int STUCK_SAMPLES = 255
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [HALL_BITS-1:0] rawHall,
  input  logic [CAR_BITS:1]    rawCar1,
  input  logic [CAR_BITS:1]    rawCar2,
  input  logic [HALL_BITS-1:0] nextRealFloorButton,
  input  logic [CAR_BITS:1]    nextRealInternalButton1,
  input  logic [CAR_BITS:1]    nextRealInternalButton2,
  output logic [HALL_BITS-1:0] realFloorButton,
  output logic [CAR_BITS:1]    realInternalButton1,
  output logic [CAR_BITS:1]    realInternalButton2,
  output logic [HALL_BITS-1:0] hallLamp,
  output logic [CAR_BITS:1]    carLamp1,
  output logic [CAR_BITS:1]    carLamp2
`ifdef STUCK_BUTTON_MASK_EN
  , output logic               stuckFault
`endif
);

  localparam int CNT_W = (CLK_PER_DEBOUNCE > 1) ? $clog2(CLK_PER_DEBOUNCE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_DEBOUNCE - 1);
  localparam logic [BUTTON_COUNT-1:0] MOMENTARY = momentaryMask();

  logic [CNT_W-1:0]        tickCnt;
  logic                    tick;
  logic [BUTTON_COUNT-1:0] rawAll;
  logic [BUTTON_COUNT-1:0] nextAll;
  logic [BUTTON_COUNT-1:0] level;
  logic [BUTTON_COUNT-1:0] press;
  logic [BUTTON_COUNT-1:0] nextPrev;
  logic [BUTTON_COUNT-1:0] ack;
  logic [BUTTON_COUNT-1:0] pending;
  logic [BUTTON_COUNT-1:0] request;
`ifdef STUCK_BUTTON_MASK_EN
  logic [BUTTON_COUNT-1:0] stuck;
`endif

  assign tick = (tickCnt == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tickCnt <= '0;
    else       tickCnt <= tick ? '0 : tickCnt + CNT_W'(1);
  end

  assign rawAll  = {rawCar2, rawCar1, rawHall};
  assign nextAll = {nextRealInternalButton2, nextRealInternalButton1, nextRealFloorButton};

  for (genvar i = 0; i < BUTTON_COUNT; i++) begin : gBtn
    button_debouncer #(
      .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)
`ifdef STUCK_BUTTON_MASK_EN
      , .STUCK_SAMPLES(STUCK_SAMPLES)
`endif
    ) uDeb (
      .clk   (clk),
      .reset (reset),
      .raw   (rawAll[i]),
      .tick  (tick),
      .level (level[i]),
      .press (press[i])
`ifdef STUCK_BUTTON_MASK_EN
      , .stuck (stuck[i])
`endif
    );
  end

  // Ack is registered so a served request clears two cycles after next* falls;
  // press is OR'd last so it wins over a coincident ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nextPrev <= '0;
      ack      <= '0;
      pending  <= '0;
    end else begin
      nextPrev <= nextAll;
      ack      <= nextPrev & ~nextAll & ~MOMENTARY;
      pending  <= ((pending & ~ack) | press) & ~MOMENTARY;
    end
  end

  assign request = (pending & ~MOMENTARY) | (level & MOMENTARY);

  assign realFloorButton     = request[HALL_BITS-1:0];
  assign realInternalButton1 = request[HALL_BITS+CAR_BITS-1:HALL_BITS];
  assign realInternalButton2 = request[BUTTON_COUNT-1:HALL_BITS+CAR_BITS];
  assign hallLamp            = realFloorButton;
  assign carLamp1            = realInternalButton1;
  assign carLamp2            = realInternalButton2;

`ifdef STUCK_BUTTON_MASK_EN
  assign stuckFault = |stuck;
`endif

endmodule

// File: tb/tb_button_panel_interface.sv
// Directed bench for button_panel_interface with a run-length debounce model checked every cycle.
module tb_button_panel_interface;

  localparam int P  = 4;
  localparam int N  = 3;
  localparam int NB = 30;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] rawHall = '0;
  logic [9:1]  rawCar1 = '0;
  logic [9:1]  rawCar2 = '0;
  logic [11:0] nextRealFloorButton = '0;
  logic [9:1]  nextRealInternalButton1 = '0;
  logic [9:1]  nextRealInternalButton2 = '0;
  logic [11:0] realFloorButton, hallLamp;
  logic [9:1]  realInternalButton1, realInternalButton2, carLamp1, carLamp2;

  int vectors = 0;
  int miscompares = 0;

  button_panel_interface #(.CLK_PER_DEBOUNCE(P), .DEBOUNCE_SAMPLES(N)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .rawHall                 (rawHall),
    .rawCar1                 (rawCar1),
    .rawCar2                 (rawCar2),
    .nextRealFloorButton     (nextRealFloorButton),
    .nextRealInternalButton1 (nextRealInternalButton1),
    .nextRealInternalButton2 (nextRealInternalButton2),
    .realFloorButton         (realFloorButton),
    .realInternalButton1     (realInternalButton1),
    .realInternalButton2     (realInternalButton2),
    .hallLamp                (hallLamp),
    .carLamp1                (carLamp1),
    .carLamp2                (carLamp2)
  );

  always #5 clk = ~clk;

  // Model: each button's debounced level is the value of the last N tick samples
  // when they all agree (tracked as a run length), else the previous level.
  int mCnt;
  int mRun[NB];
  bit mSync1[NB], mSync2[NB], mLast[NB], mLevel[NB], mLevelD[NB];
  bit mNextPrev[NB], mAck[NB], mPend[NB];

  function automatic bit isMomentary(input int i);
    return (i == 19) || (i == 20) || (i == 28) || (i == 29);
  endfunction

  task automatic modelReset();
    mCnt = 0;
    for (int i = 0; i < NB; i++) begin
      mRun[i] = N; mLast[i] = 0; mSync1[i] = 0; mSync2[i] = 0;
      mLevel[i] = 0; mLevelD[i] = 0; mNextPrev[i] = 0; mAck[i] = 0; mPend[i] = 0;
    end
  endtask

  task automatic modelStep(input logic [29:0] r, input logic [29:0] n);
    bit tickNow, pressNow, newLevel;
    tickNow = (mCnt == P - 1);
    for (int i = 0; i < NB; i++) begin
      pressNow = mLevel[i] && !mLevelD[i];
      newLevel = (mRun[i] >= N) ? mLast[i] : mLevel[i];
      if (tickNow) begin
        if (mSync2[i] == mLast[i]) begin
          if (mRun[i] < N) mRun[i]++;
        end else begin
          mLast[i] = mSync2[i];
          mRun[i] = 1;
        end
      end
      mSync2[i] = mSync1[i];
      mSync1[i] = r[i];
      if (!isMomentary(i)) mPend[i] = (mPend[i] && !mAck[i]) || pressNow;
      mAck[i] = mNextPrev[i] && !n[i] && !isMomentary(i);
      mNextPrev[i] = n[i];
      mLevelD[i] = mLevel[i];
      mLevel[i] = newLevel;
    end
    mCnt = (mCnt + 1) % P;
  endtask

  task automatic checkVec(input string name, input logic [29:0] act, input logic [29:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, req, $time);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  logic [29:0] actReq, actLamp, expv;

  always @(negedge clk) begin
    actReq  = {realInternalButton2, realInternalButton1, realFloorButton};
    actLamp = {carLamp2, carLamp1, hallLamp};
    if (reset) modelReset();
    for (int i = 0; i < NB; i++) expv[i] = isMomentary(i) ? mLevel[i] : mPend[i];
    checkVec("model_requests", actReq, expv);
    checkVec("model_lamps", actLamp, expv);
    if (!reset)
      modelStep({rawCar2, rawCar1, rawHall},
                {nextRealInternalButton2, nextRealInternalButton1, nextRealFloorButton});
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, miscompares=%0d", miscompares);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    bit found;
    bit fell;

    waitCycles(3);
    reset = 1'b0;
    #1;
    checkVec("reset_state", {realInternalButton2, realInternalButton1, realFloorButton}, 30'd0);

    // 1: hall bit 2 held; edge 1 sync, ticks at edges 4/8/12, level at 13, pending at 14
    rawHall[2] = 1'b1;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (lat == 0 && realFloorButton[2]) lat = n;
    end
    #1;
    checkInt("t1_latency", lat, 14);
    rawHall[2] = 1'b0;
    waitCycles(20);
    checkBit("t1_hold_after_release", realFloorButton[2], 1'b1);
    checkBit("t1_lamp", hallLamp[2], 1'b1);
    checkBit("t1_model_pin", mPend[2], 1'b1);

    // 2: bounce every 3 cycles never yields three equal-high samples
    for (int c = 0; c < 40; c++) begin
      if (c % 3 == 0) rawCar1[3] = ~rawCar1[3];
      waitCycles(1);
    end
    rawCar1[3] = 1'b0;
    waitCycles(20);
    checkBit("t2_bounce_rejected", realInternalButton1[3], 1'b0);

    // 3: ack clears exactly 2 cycles after next* falls
    rawHall[5] = 1'b1;
    waitCycles(20);
    rawHall[5] = 1'b0;
    waitCycles(20);
    checkBit("t3_pending", realFloorButton[5], 1'b1);
    nextRealFloorButton[5] = 1'b1;
    waitCycles(3);
    nextRealFloorButton[5] = 1'b0;
    @(posedge clk); #1;
    checkBit("t3_ack_plus1", realFloorButton[5], 1'b1);
    @(posedge clk); #1;
    checkBit("t3_ack_plus2", realFloorButton[5], 1'b0);
    #1;

    // 4: door-open is momentary, ignores ack, drops on release
    rawCar2[8] = 1'b1;
    waitCycles(20);
    checkBit("t4_follow_level", realInternalButton2[8], 1'b1);
    nextRealInternalButton2[8] = 1'b1;
    waitCycles(3);
    nextRealInternalButton2[8] = 1'b0;
    waitCycles(4);
    checkBit("t4_ack_ignored", carLamp2[8], 1'b1);
    rawCar2[8] = 1'b0;
    fell = 1'b0;
    for (int n = 0; n < 30 && !fell; n++) begin
      waitCycles(1);
      if (!realInternalButton2[8]) fell = 1'b1;
    end
    checkBit("t4_falls_on_release", fell, 1'b1);

    // 5: re-press of pending hall bit 0 coinciding with its ack
    rawHall[0] = 1'b1;
    waitCycles(20);
    rawHall[0] = 1'b0;
    waitCycles(20);
    checkBit("t5_pending", realFloorButton[0], 1'b1);
    nextRealFloorButton[0] = 1'b1;
    waitCycles(2);
    rawHall[0] = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 30 && !found; n++) begin
      waitCycles(1);
      if (mRun[0] >= N && mLast[0] && !mLevel[0]) begin
        nextRealFloorButton[0] = 1'b0;
        found = 1'b1;
      end
    end
    checkBit("t5_alignment_found", found, 1'b1);
    @(posedge clk); #1;
    checkBit("t5_edge_ack", realFloorButton[0], 1'b1);
    @(posedge clk); #1;
    checkBit("t5_press_wins", realFloorButton[0], 1'b1);
    checkBit("t5_model_pin", mPend[0], 1'b1);
    #1;
    rawHall[0] = 1'b0;

    // 6: async reset mid-debounce with hall 7/8/9 pending
    rawHall[9:7] = 3'b111;
    waitCycles(20);
    rawHall[9:7] = 3'b000;
    waitCycles(4);
    checkVec("t6_pending_before", {18'd0, realFloorButton & 12'h380}, 30'h380);
    rawCar1[4] = 1'b1;
    waitCycles(6);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    checkVec("t6_async_clear_req", {realInternalButton2, realInternalButton1, realFloorButton}, 30'd0);
    checkVec("t6_async_clear_lamp", {carLamp2, carLamp1, hallLamp}, 30'd0);
    rawCar1[4] = 1'b0;
    nextRealFloorButton = '0;
    waitCycles(2);
    reset = 1'b0;
    waitCycles(30);
    checkVec("t6_no_set_after_release", {realInternalButton2, realInternalButton1, realFloorButton}, 30'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
